// File: rtl/mccu_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcode map,
// ALU operation selects and the packed control vector.
package mccu_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExecute,
    StMem,
    StWriteback,
    StHalt,
    StTrap
  } state_e;

  localparam int unsigned OpAdd  = 0;
  localparam int unsigned OpSub  = 1;
  localparam int unsigned OpAnd  = 2;
  localparam int unsigned OpOr   = 3;
  localparam int unsigned OpAddi = 4;
  localparam int unsigned OpLw   = 5;
  localparam int unsigned OpSw   = 6;
  localparam int unsigned OpBeq  = 7;
  localparam int unsigned OpJmp  = 8;
  localparam int unsigned OpHalt = 9;

  localparam int unsigned AluAdd = 0;
  localparam int unsigned AluSub = 1;
  localparam int unsigned AluAnd = 2;
  localparam int unsigned AluOr  = 3;

  typedef struct packed {
    logic pc_write;
    logic ir_write;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic alu_src;
    logic mem_to_reg;
    logic pc_src;
    logic imm_select;
    logic halted;
    logic illegal;
  } ctrl_t;

  // Anything above HALT in the opcode space traps.
  function automatic logic is_legal(int unsigned op);
    return op <= OpHalt;
  endfunction

endpackage

// File: rtl/mccu_decoder.sv
// Combinational map from {state, opcode, zero, memory ready} to the datapath
// control vector and ALU operation select.
module mccu_decoder
  import mccu_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALUOP_W  = 4
) (
  input  state_e              state,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_rdy,
  output ctrl_t               ctrl,
  output logic [ALUOP_W-1:0]  alu_op
);

  int unsigned op;

  always_comb begin
    ctrl   = '0;
    alu_op = '0;
    op     = 32'(opcode);
    case (state)
      StFetch: begin
        ctrl.mem_read = 1'b1;
        ctrl.ir_write = 1'b1;
        // PC advances only once the fetch actually completes.
        ctrl.pc_write = mem_rdy;
      end
      StExecute: begin
        case (op)
          OpAdd, OpAddi, OpLw, OpSw: alu_op = ALUOP_W'(AluAdd);
          OpSub, OpBeq:              alu_op = ALUOP_W'(AluSub);
          OpAnd:                     alu_op = ALUOP_W'(AluAnd);
          OpOr:                      alu_op = ALUOP_W'(AluOr);
          default:                   alu_op = '0;
        endcase
        ctrl.alu_src = (op == OpAddi) || (op == OpLw) || (op == OpSw);
        if ((op == OpJmp) || ((op == OpBeq) && zero)) begin
          ctrl.pc_write   = 1'b1;
          ctrl.pc_src     = 1'b1;
          ctrl.imm_select = 1'b1;
        end
      end
      StMem: begin
        ctrl.mem_read  = (op == OpLw);
        ctrl.mem_write = (op == OpSw);
      end
      StWriteback: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = (op == OpLw);
      end
      StHalt:  ctrl.halted  = 1'b1;
      StTrap:  ctrl.illegal = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM: state register, transitions with memory-ready
// handshake, retired-instruction counter and reset-gated control outputs.
module multicycle_control_unit
  import mccu_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALUOP_W  = 4,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  input  logic                resume,
  output logic                PC_write,
  output logic                IR_write,
  output logic                RegWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                ALUsrc,
  output logic                MemtoReg,
  output logic                PCsrc,
  output logic                Imm_select,
  output logic [ALUOP_W-1:0]  ALUop,
  output logic                halted,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             mem_rdy;
  logic             retire;
  int unsigned      op;
  ctrl_t            ctrl;
  logic [ALUOP_W-1:0] alu_op;

  assign mem_rdy = (MEM_WAIT == 0) ? 1'b1 : mem_ready;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    op      = 32'(opcode);
    case (state_q)
      StFetch: if (mem_rdy) state_d = StDecode;
      StDecode: begin
        if (op == OpHalt)     state_d = StHalt;
        else if (!is_legal(op)) state_d = StTrap;
        else                  state_d = StExecute;
      end
      StExecute: begin
        if ((op == OpBeq) || (op == OpJmp)) begin
          state_d = StFetch;
          retire  = 1'b1;
        end else if ((op == OpLw) || (op == OpSw)) begin
          state_d = StMem;
        end else begin
          state_d = StWriteback;
        end
      end
      StMem: begin
        if (mem_rdy) begin
          if (op == OpSw) begin
            state_d = StFetch;
            retire  = 1'b1;
          end else begin
            state_d = StWriteback;
          end
        end
      end
      StWriteback: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StHalt, StTrap: if (resume) state_d = StFetch;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StFetch;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  mccu_decoder #(
    .OPCODE_W(OPCODE_W),
    .ALUOP_W (ALUOP_W)
  ) u_decoder (
    .state  (state_q),
    .opcode (opcode),
    .zero   (zero),
    .mem_rdy(mem_rdy),
    .ctrl   (ctrl),
    .alu_op (alu_op)
  );

  // Gate with reset so an in-flight store is dropped the moment reset asserts.
  assign PC_write   = reset & ctrl.pc_write;
  assign IR_write   = reset & ctrl.ir_write;
  assign RegWrite   = reset & ctrl.reg_write;
  assign MemRead    = reset & ctrl.mem_read;
  assign MemWrite   = reset & ctrl.mem_write;
  assign ALUsrc     = reset & ctrl.alu_src;
  assign MemtoReg   = reset & ctrl.mem_to_reg;
  assign PCsrc      = reset & ctrl.pc_src;
  assign Imm_select = reset & ctrl.imm_select;
  assign halted     = reset & ctrl.halted;
  assign illegal    = reset & ctrl.illegal;
  assign ALUop      = reset ? alu_op : '0;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed vector bench for multicycle_control_unit (CNT_W = 4 to reach wrap).
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       resume = 1'b0;
  logic       PC_write, IR_write, RegWrite, MemRead, MemWrite, ALUsrc, MemtoReg;
  logic       PCsrc, Imm_select, halted, illegal;
  logic [3:0] ALUop;
  logic [3:0] retired;

  multicycle_control_unit #(
    .OPCODE_W(4),
    .ALUOP_W (4),
    .CNT_W   (4),
    .MEM_WAIT(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .resume    (resume),
    .PC_write  (PC_write),
    .IR_write  (IR_write),
    .RegWrite  (RegWrite),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .ALUsrc    (ALUsrc),
    .MemtoReg  (MemtoReg),
    .PCsrc     (PCsrc),
    .Imm_select(Imm_select),
    .ALUop     (ALUop),
    .halted    (halted),
    .illegal   (illegal),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  logic [10:0] act;
  assign act = {PC_write, IR_write, RegWrite, MemRead, MemWrite, ALUsrc, MemtoReg,
                PCsrc, Imm_select, halted, illegal};

  // Bit order: pc_write ir_write reg_write mem_read mem_write alu_src
  //            mem_to_reg pc_src imm_select halted illegal
  localparam logic [10:0] CF  = 11'b11010000000;
  localparam logic [10:0] CFW = 11'b01010000000;
  localparam logic [10:0] CN  = 11'b00000000000;
  localparam logic [10:0] CWB = 11'b00100000000;
  localparam logic [10:0] CEI = 11'b00000100000;
  localparam logic [10:0] CML = 11'b00010000000;
  localparam logic [10:0] CMS = 11'b00001000000;
  localparam logic [10:0] CWL = 11'b00100010000;
  localparam logic [10:0] CBR = 11'b10000001100;
  localparam logic [10:0] CH  = 11'b00000000010;
  localparam logic [10:0] CT  = 11'b00000000001;

  typedef struct {
    logic [3:0]  op;
    logic        z;
    logic        rdy;
    logic        res;
    logic [10:0] ctrl;
    logic [3:0]  alu;
    logic [3:0]  ret;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad = 0;

  function automatic void row(logic [3:0] op, logic z, logic rdy, logic res,
                              logic [10:0] c, logic [3:0] alu, logic [3:0] ret);
    vec_t v;
    v.op = op; v.z = z; v.rdy = rdy; v.res = res; v.ctrl = c; v.alu = alu; v.ret = ret;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, a, e);
    end
  endtask

  task automatic drive(logic [3:0] op, logic z, logic rdy, logic res);
    @(negedge clk);
    opcode = op; zero = z; mem_ready = rdy; resume = res;
    #1;
  endtask

  task automatic chk_all(string name, logic [10:0] c, logic [3:0] alu, logic [3:0] ret);
    chk({name, " ctrl"}, 32'(act), 32'(c));
    chk({name, " aluop"}, 32'(ALUop), 32'(alu));
    chk({name, " retired"}, 32'(retired), 32'(ret));
  endtask

  initial begin
    // ADD: F D E(zero=1, resume=1 ignored) WB
    row(0, 0, 1, 0, CF, 0, 0); row(0, 0, 1, 0, CN, 0, 0);
    row(0, 1, 1, 1, CN, 0, 0); row(0, 0, 1, 0, CWB, 0, 0);
    row(1, 0, 1, 0, CF, 0, 1); row(1, 0, 1, 0, CN, 0, 1);
    row(1, 0, 1, 0, CN, 1, 1); row(1, 0, 1, 0, CWB, 0, 1);
    row(2, 0, 1, 0, CF, 0, 2); row(2, 0, 1, 0, CN, 0, 2);
    row(2, 0, 1, 0, CN, 2, 2); row(2, 0, 1, 0, CWB, 0, 2);
    row(3, 0, 1, 0, CF, 0, 3); row(3, 0, 1, 0, CN, 0, 3);
    row(3, 0, 1, 0, CN, 3, 3); row(3, 0, 1, 0, CWB, 0, 3);
    row(4, 0, 1, 0, CF, 0, 4); row(4, 0, 1, 0, CN, 0, 4);
    row(4, 0, 1, 0, CEI, 0, 4); row(4, 0, 1, 0, CWB, 0, 4);
    // LW with three wait cycles in MEM: 8 cycles total
    row(5, 0, 1, 0, CF, 0, 5); row(5, 0, 1, 0, CN, 0, 5); row(5, 0, 1, 0, CEI, 0, 5);
    row(5, 0, 0, 0, CML, 0, 5); row(5, 0, 0, 0, CML, 0, 5); row(5, 0, 0, 0, CML, 0, 5);
    row(5, 0, 1, 0, CML, 0, 5); row(5, 0, 1, 0, CWL, 0, 5);
    // SW with one fetch wait cycle
    row(6, 0, 0, 0, CFW, 0, 6); row(6, 0, 1, 0, CF, 0, 6); row(6, 0, 1, 0, CN, 0, 6);
    row(6, 0, 1, 0, CEI, 0, 6); row(6, 0, 1, 0, CMS, 0, 6);
    // BEQ taken, BEQ not taken, JMP: 3 cycles each
    row(7, 1, 1, 0, CF, 0, 7); row(7, 1, 1, 0, CN, 0, 7); row(7, 1, 1, 0, CBR, 1, 7);
    row(7, 0, 1, 0, CF, 0, 8); row(7, 0, 1, 0, CN, 0, 8); row(7, 0, 1, 0, CN, 1, 8);
    row(8, 0, 1, 0, CF, 0, 9); row(8, 0, 1, 0, CN, 0, 9); row(8, 0, 1, 0, CBR, 0, 9);
    // Illegal opcode 12: TRAP held 5 cycles, then resume
    row(12, 0, 1, 0, CF, 0, 10); row(12, 0, 1, 0, CN, 0, 10);
    for (int k = 0; k < 5; k++) row(12, 0, 1, 0, CT, 0, 10);
    row(12, 0, 1, 1, CT, 0, 10);
    // HALT: resume in DECODE ignored, held, then resume
    row(9, 0, 1, 0, CF, 0, 10); row(9, 0, 1, 1, CN, 0, 10);
    for (int k = 0; k < 3; k++) row(9, 0, 1, 0, CH, 0, 10);
    row(9, 0, 1, 1, CH, 0, 10);

    // Reset asserted during FETCH with mem_ready high
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      chk_all($sformatf("reset%0d", k), CN, 0, 0);
    end
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].z, vecs[i].rdy, vecs[i].res);
      chk_all($sformatf("row%0d", i), vecs[i].ctrl, vecs[i].alu, vecs[i].ret);
    end

    // Five more ADDs bring the 4-bit counter to 15
    for (int n = 0; n < 5; n++)
      for (int c = 0; c < 4; c++) drive(0, 0, 1, 0);
    drive(9, 0, 1, 0);
    chk_all("pre_halt fetch", CF, 0, 15);
    drive(9, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      drive(9, 0, 1, 0);
      chk_all($sformatf("halt%0d", k), CH, 0, 15);
    end
    drive(9, 0, 1, 1);
    for (int c = 0; c < 4; c++) drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    chk_all("wrap", CF, 0, 0);

    // Reset asserted while SW is waiting in MEM
    drive(6, 0, 1, 0);
    drive(6, 0, 1, 0);
    drive(6, 0, 0, 0);
    chk_all("sw mem wait", CMS, 0, 0);
    reset = 1'b0;
    #1;
    chk_all("async reset in mem", CN, 0, 0);
    @(posedge clk); #1;
    chk_all("reset held", CN, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(6, 0, 0, 0);
    chk_all("after reset fetch", CFW, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
